// File: rtl/rtos_sched_rr.sv
// rtl/rtos_sched_rr.sv - priority scheduler with round-robin time slicing among equal-priority ready tasks
module rtos_sched_rr #(
  parameter  int NTASK     = 8,
  parameter  int PRIO_W    = 3,
  parameter  int SLICE_W   = 4,
  parameter  int TCB_BYTES = 64,
  localparam int IDX_W     = $clog2(NTASK)
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               tick_in,
  input  logic [NTASK-1:0]   ready_in,
  input  logic               prio_wr_en,
  input  logic [IDX_W-1:0]   prio_wr_idx,
  input  logic [PRIO_W-1:0]  prio_wr_data,
  input  logic [SLICE_W-1:0] slice_len_in,
  input  logic [31:0]        tcb_base_in,
  input  logic               switch_ack_in,
  output logic               switch_req_out,
  output logic [IDX_W-1:0]   next_idx_out,
  output logic [31:0]        next_tcb_out,
  output logic               cur_valid_out,
  output logic [IDX_W-1:0]   cur_idx_out,
  output logic [31:0]        addrTCB_out
);

  typedef enum logic [1:0] {IDLE, RUN, SELECT, SWITCH} state_t;

  state_t              state;
  logic [PRIO_W-1:0]   prio_tab [NTASK];
  logic                tick_q;
  logic                tick;
  logic [SLICE_W-1:0]  slice_cnt;
  logic [SLICE_W-1:0]  slice_reload;
  logic [IDX_W-1:0]    cur_idx;
  logic [IDX_W-1:0]    next_idx;
  logic                cur_valid;
  logic                switch_req;
  logic [PRIO_W-1:0]   cur_prio;
  logic                higher_rdy;
  logic                peer_rdy;
  logic [IDX_W-1:0]    scan_start;
  logic [IDX_W:0]      slot;
  logic                pick_found;
  logic [IDX_W-1:0]    pick_idx;
  logic [PRIO_W-1:0]   pick_prio;

  assign tick         = tick_in & ~tick_q;
  assign slice_reload = (slice_len_in == '0) ? SLICE_W'(1) : slice_len_in;
  assign cur_prio     = prio_tab[cur_idx];

  // Preemption and slice-expiry candidates relative to the running task
  always_comb begin
    higher_rdy = 1'b0;
    peer_rdy   = 1'b0;
    for (int j = 0; j < NTASK; j++) begin
      if (ready_in[j] && (prio_tab[j] > cur_prio))
        higher_rdy = 1'b1;
      if (ready_in[j] && (prio_tab[j] == cur_prio) && (IDX_W'(j) != cur_idx))
        peer_rdy = 1'b1;
    end
  end

  // Circular scan from the slot after the running task; strict > keeps the first tie seen
  always_comb begin
    scan_start = '0;
    if (cur_valid && ({1'b0, cur_idx} != (IDX_W+1)'(NTASK - 1)))
      scan_start = cur_idx + IDX_W'(1);
    slot       = '0;
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_prio  = '0;
    for (int k = 0; k < NTASK; k++) begin
      slot = {1'b0, scan_start} + (IDX_W+1)'(k);
      if (slot >= (IDX_W+1)'(NTASK))
        slot = slot - (IDX_W+1)'(NTASK);
      if (ready_in[slot[IDX_W-1:0]] && (!pick_found || (prio_tab[slot[IDX_W-1:0]] > pick_prio))) begin
        pick_found = 1'b1;
        pick_idx   = slot[IDX_W-1:0];
        pick_prio  = prio_tab[slot[IDX_W-1:0]];
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state      <= IDLE;
      switch_req <= 1'b0;
      cur_valid  <= 1'b0;
      cur_idx    <= '0;
      next_idx   <= '0;
      slice_cnt  <= SLICE_W'(1);
      tick_q     <= 1'b0;
      for (int i = 0; i < NTASK; i++)
        prio_tab[i] <= '0;
    end else begin
      tick_q <= tick_in;
      if (prio_wr_en && ({1'b0, prio_wr_idx} < (IDX_W+1)'(NTASK)))
        prio_tab[prio_wr_idx] <= prio_wr_data;
      case (state)
        IDLE: begin
          if (|ready_in)
            state <= SELECT;
        end
        RUN: begin
          if (!ready_in[cur_idx] || higher_rdy || (tick && (slice_cnt == SLICE_W'(1)) && peer_rdy))
            state <= SELECT;
          else if (tick && (slice_cnt > SLICE_W'(1)))
            slice_cnt <= slice_cnt - SLICE_W'(1);
        end
        SELECT: begin
          if (!pick_found) begin
            state     <= IDLE;
            cur_valid <= 1'b0;
          end else if (cur_valid && (pick_idx == cur_idx)) begin
            state     <= RUN;
            slice_cnt <= slice_reload;
          end else begin
            next_idx   <= pick_idx;
            switch_req <= 1'b1;
            state      <= SWITCH;
          end
        end
        SWITCH: begin
          if (switch_ack_in) begin
            cur_idx    <= next_idx;
            cur_valid  <= 1'b1;
            slice_cnt  <= slice_reload;
            switch_req <= 1'b0;
            state      <= RUN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign switch_req_out = switch_req;
  assign next_idx_out   = next_idx;
  assign cur_valid_out  = cur_valid;
  assign cur_idx_out    = cur_idx;
  assign next_tcb_out   = tcb_base_in + 32'(next_idx) * 32'(TCB_BYTES);
  assign addrTCB_out    = tcb_base_in + 32'(cur_idx) * 32'(TCB_BYTES);

endmodule

// File: tb/tb_rtos_sched_rr.sv
// tb/tb_rtos_sched_rr.sv - directed and randomized checks of rtos_sched_rr against a behavioural model
module tb_rtos_sched_rr;
  localparam int NTASK     = 8;
  localparam int PRIO_W    = 3;
  localparam int SLICE_W   = 4;
  localparam int TCB_BYTES = 64;
  localparam int IDX_W     = 3;

  logic               aclk = 1'b0;
  logic               aresetn;
  logic               tick_in;
  logic [NTASK-1:0]   ready_in;
  logic               prio_wr_en;
  logic [IDX_W-1:0]   prio_wr_idx;
  logic [PRIO_W-1:0]  prio_wr_data;
  logic [SLICE_W-1:0] slice_len_in;
  logic [31:0]        tcb_base_in;
  logic               switch_ack_in;
  logic               switch_req_out;
  logic [IDX_W-1:0]   next_idx_out;
  logic [31:0]        next_tcb_out;
  logic               cur_valid_out;
  logic [IDX_W-1:0]   cur_idx_out;
  logic [31:0]        addrTCB_out;

  always #5 aclk = ~aclk;

  rtos_sched_rr #(.NTASK(NTASK), .PRIO_W(PRIO_W), .SLICE_W(SLICE_W), .TCB_BYTES(TCB_BYTES)) dut (
    .aclk(aclk), .aresetn(aresetn), .tick_in(tick_in), .ready_in(ready_in),
    .prio_wr_en(prio_wr_en), .prio_wr_idx(prio_wr_idx), .prio_wr_data(prio_wr_data),
    .slice_len_in(slice_len_in), .tcb_base_in(tcb_base_in), .switch_ack_in(switch_ack_in),
    .switch_req_out(switch_req_out), .next_idx_out(next_idx_out), .next_tcb_out(next_tcb_out),
    .cur_valid_out(cur_valid_out), .cur_idx_out(cur_idx_out), .addrTCB_out(addrTCB_out)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  // Model: mode 0 idle, 1 running, 2 choosing, 3 awaiting ack
  int m_mode, m_cur, m_next, m_slice;
  bit m_valid, m_req, m_tick_prev;
  int m_prio [NTASK];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int max_ready_prio();
    int best;
    best = -1;
    for (int j = 0; j < NTASK; j++)
      if (ready_in[j] && m_prio[j] > best) best = m_prio[j];
    return best;
  endfunction

  function automatic int rr_pick();
    int best, start, t;
    best  = max_ready_prio();
    start = m_valid ? (m_cur + 1) % NTASK : 0;
    if (best < 0) return -1;
    for (int k = 0; k < NTASK; k++) begin
      t = (start + k) % NTASK;
      if (ready_in[t] && m_prio[t] == best) return t;
    end
    return -1;
  endfunction

  task automatic model_step();
    bit tick, peer;
    int p, reload;
    tick = tick_in && !m_tick_prev;
    if (!aresetn) begin
      m_mode = 0; m_cur = 0; m_next = 0; m_slice = 1;
      m_valid = 0; m_req = 0; m_tick_prev = 0;
      for (int j = 0; j < NTASK; j++) m_prio[j] = 0;
      return;
    end
    m_tick_prev = tick_in;
    reload = (slice_len_in == 0) ? 1 : int'(slice_len_in);
    case (m_mode)
      0: if (ready_in != 0) m_mode = 2;
      1: begin
        peer = 0;
        for (int j = 0; j < NTASK; j++)
          if (j != m_cur && ready_in[j] && m_prio[j] == m_prio[m_cur]) peer = 1;
        if (!ready_in[m_cur] || max_ready_prio() > m_prio[m_cur] || (tick && m_slice == 1 && peer))
          m_mode = 2;
        else if (tick && m_slice > 1)
          m_slice = m_slice - 1;
      end
      2: begin
        p = rr_pick();
        if (p < 0) begin
          m_mode = 0; m_valid = 0;
        end else if (m_valid && p == m_cur) begin
          m_mode = 1; m_slice = reload;
        end else begin
          m_next = p; m_req = 1; m_mode = 3;
        end
      end
      default: if (switch_ack_in) begin
        m_cur = m_next; m_valid = 1; m_slice = reload; m_req = 0; m_mode = 1;
      end
    endcase
    if (prio_wr_en) m_prio[prio_wr_idx] = int'(prio_wr_data);
  endtask

  always @(negedge aclk) begin
    if (chk_en) begin
      check("switch_req", 32'(switch_req_out), 32'(m_req));
      check("next_idx", 32'(next_idx_out), 32'(m_next));
      check("next_tcb", next_tcb_out, tcb_base_in + 32'(m_next * TCB_BYTES));
      check("cur_valid", 32'(cur_valid_out), 32'(m_valid));
      check("cur_idx", 32'(cur_idx_out), 32'(m_cur));
      check("addr_tcb", addrTCB_out, tcb_base_in + 32'(m_cur * TCB_BYTES));
    end
  end

  task automatic cyc();
    @(posedge aclk);
    model_step();
    #2;
  endtask

  task automatic wait_req(input int max, input string name);
    int i;
    i = 0;
    while (!switch_req_out && i < max) begin
      cyc();
      i++;
    end
    n_tests++;
    if (!switch_req_out) begin
      n_fail++;
      $display("FAIL %s: switch_req_out still 0 after %0d cycles", name, max);
    end
  endtask

  task automatic ack();
    switch_ack_in = 1'b1;
    cyc();
    switch_ack_in = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int order [4];
    int exp_order [4];
    exp_order = '{1, 3, 6, 1};
    aresetn = 0; tick_in = 0; ready_in = '0; prio_wr_en = 0; prio_wr_idx = '0;
    prio_wr_data = '0; slice_len_in = 4'd2; tcb_base_in = 32'h1000; switch_ack_in = 0;
    cyc();
    chk_en = 1;
    cyc();
    check("rst_switch_req", 32'(switch_req_out), 0);
    check("rst_cur_valid", 32'(cur_valid_out), 0);
    check("rst_cur_idx", 32'(cur_idx_out), 0);
    check("rst_next_idx", 32'(next_idx_out), 0);
    check("rst_addr_tcb", addrTCB_out, 32'h1000);
    check("rst_next_tcb", next_tcb_out, 32'h1000);
    aresetn = 1;

    // Higher priority wins among two ready tasks
    prio_wr_en = 1; prio_wr_idx = 3'd1; prio_wr_data = 3'd3; cyc();
    prio_wr_idx = 3'd2; prio_wr_data = 3'd5; cyc();
    prio_wr_en = 0;
    ready_in = 8'b0000_0110;
    wait_req(6, "t038_req");
    check("t038_next_idx", 32'(next_idx_out), 2);
    check("t038_next_tcb", next_tcb_out, 32'h1080);
    ack();
    check("t038_cur_idx", 32'(cur_idx_out), 2);
    check("t038_addr_tcb", addrTCB_out, 32'h1080);
    check("t038_cur_valid", 32'(cur_valid_out), 1);

    // Preemption by a newly ready higher-priority task, request held without ack
    prio_wr_en = 1; prio_wr_idx = 3'd5; prio_wr_data = 3'd7; cyc();
    prio_wr_en = 0;
    ready_in = 8'b0010_0110;
    cyc(); cyc();
    check("t039_req_in_2", 32'(switch_req_out), 1);
    check("t039_next_idx", 32'(next_idx_out), 5);
    for (int i = 0; i < 10; i++) begin
      ready_in = NTASK'($urandom);
      tick_in = ~tick_in;
      cyc();
      check("t039_hold_req", 32'(switch_req_out), 1);
      check("t039_hold_idx", 32'(next_idx_out), 5);
      check("t039_hold_tcb", next_tcb_out, 32'h1140);
    end
    tick_in = 0;
    ready_in = 8'b0010_0110;
    ack();
    check("t039_cur_idx", 32'(cur_idx_out), 5);

    // Reset while a request is pending clears request and priority table
    ready_in = 8'b0000_1000;
    wait_req(6, "t042_req");
    check("t042_next_idx", 32'(next_idx_out), 3);
    aresetn = 0;
    cyc();
    check("t042_req_cleared", 32'(switch_req_out), 0);
    check("t042_cur_valid", 32'(cur_valid_out), 0);
    aresetn = 1;
    ready_in = 8'b0000_0110;
    wait_req(6, "t042_req2");
    check("t042_prio_zeroed", 32'(next_idx_out), 1);
    ack();

    // Round-robin slicing among equal priorities; a held tick counts once
    aresetn = 0; cyc(); aresetn = 1;
    slice_len_in = 4'd2;
    ready_in = 8'b0100_1010;
    for (int n = 0; n < 4; n++) begin
      wait_req(8, "t040_req");
      order[n] = int'(next_idx_out);
      ack();
      if (n < 3) begin
        tick_in = 1;
        repeat ((n == 0) ? 5 : 1) cyc();
        tick_in = 0;
        cyc(); cyc();
        check("t040_no_early_switch", 32'(switch_req_out), 0);
        tick_in = 1; cyc(); tick_in = 0;
      end
    end
    for (int n = 0; n < 4; n++) check("t040_order", 32'(order[n]), 32'(exp_order[n]));

    // Sole running task goes unready, then returns
    ready_in = 8'b0000_0010;
    repeat (3) cyc();
    check("t041_running", 32'(cur_valid_out), 1);
    check("t041_running_idx", 32'(cur_idx_out), 1);
    ready_in = '0;
    repeat (3) cyc();
    check("t041_idle_valid", 32'(cur_valid_out), 0);
    check("t041_idle_req", 32'(switch_req_out), 0);
    ready_in = 8'b0000_0010;
    wait_req(6, "t041_req");
    check("t041_next_idx", 32'(next_idx_out), 1);
    ack();

    // TCB address wraps modulo 2^32
    aresetn = 0; cyc(); aresetn = 1;
    tcb_base_in = 32'hFFFF_FFC0;
    ready_in = 8'b0000_0010;
    wait_req(6, "t043_req");
    check("t043_next_tcb", next_tcb_out, 32'h0000_0000);
    ack();
    check("t043_addr_tcb", addrTCB_out, 32'h0000_0000);

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) ready_in = NTASK'($urandom);
      if ($urandom_range(0, 3) == 0) tick_in = ~tick_in;
      switch_ack_in = ($urandom_range(0, 2) == 0);
      prio_wr_en    = ($urandom_range(0, 5) == 0);
      prio_wr_idx   = IDX_W'($urandom);
      prio_wr_data  = PRIO_W'($urandom);
      if ($urandom_range(0, 63) == 0) slice_len_in = SLICE_W'($urandom_range(0, 3));
      if ($urandom_range(0, 255) == 0) tcb_base_in = $urandom;
      aresetn = ($urandom_range(0, 399) != 0);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
